// File: rtl/sp_render_bank_pkg.sv
// Shared PPU sprite package: slot record, scan FSM states, attribute bit
// indices and a small bit-reverse helper used when loading flipped sprites.
package sp_render_bank_pkg;

  // Attribute byte layout
  localparam int ATTR_PAL_LSB = 0;
  localparam int ATTR_PAL_MSB = 1;
  localparam int ATTR_PRIO    = 5;
  localparam int ATTR_HFLIP   = 6;

  // Pattern shifter runs for exactly one tile width
  localparam logic [3:0] SHIFT_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] attr;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       is_zero;
    logic       loaded;
  } slot_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sp_slot.sv
// One sprite slot: X down-counter plus MSB-first pattern shifter.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          drop the slot (end of line)
//   load           store the presented entry into this slot
//   shift          one accepted pixel column in the active line
//   load_*         entry fields (x, attr, lo, hi, is_zero)
//   color          2-bit pixel at the current column (0 = transparent)
//   pal, prio      palette and priority of the stored sprite
//   zero_px        slot holds OAM sprite 0 and its current pixel is opaque
// Config macro: SP_ZERO_HIT_EN (when undefined the is_zero flag is not kept).
module sp_slot
  import sp_render_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_x,
  input  logic [7:0] load_attr,
  input  logic [7:0] load_lo,
  input  logic [7:0] load_hi,
  input  logic       load_is_zero,
  output logic [1:0] color,
  output logic [1:0] pal,
  output logic       prio,
  output logic       zero_px
);

  slot_t      s;
  logic [3:0] sh_cnt;
  logic       live;
  logic       unused_ok;

  // Pixel comes from the shifter MSBs once the X counter has run out,
  // and only for the first eight columns after that.
  assign live    = s.loaded && (s.x == 8'd0) && (sh_cnt != SHIFT_MAX);
  assign color   = live ? {s.hi[7], s.lo[7]} : 2'b00;
  assign pal     = s.attr[ATTR_PAL_MSB:ATTR_PAL_LSB];
  assign prio    = s.attr[ATTR_PRIO];
  assign zero_px = s.is_zero && (color != 2'b00);

  assign unused_ok = ^{load_is_zero, s.attr[7:6], s.attr[4:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= '0;
      sh_cnt <= '0;
    end else if (clear) begin
      s      <= '0;
      sh_cnt <= '0;
    end else if (load) begin
      s.x    <= load_x;
      s.attr <= load_attr;
      // Flipped sprites are stored reversed so the shifter is always MSB-first
      s.lo   <= load_attr[ATTR_HFLIP] ? bit_rev8(load_lo) : load_lo;
      s.hi   <= load_attr[ATTR_HFLIP] ? bit_rev8(load_hi) : load_hi;
`ifdef SP_ZERO_HIT_EN
      s.is_zero <= load_is_zero;
`else
      s.is_zero <= 1'b0;
`endif
      s.loaded <= 1'b1;
      sh_cnt   <= '0;
    end else if (shift && s.loaded) begin
      if (s.x != 8'd0) begin
        s.x <= s.x - 8'd1;
      end else if (sh_cnt != SHIFT_MAX) begin
        s.lo   <= {s.lo[6:0], 1'b0};
        s.hi   <= {s.hi[6:0], 1'b0};
        sh_cnt <= sh_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sp_render_bank.sv
// Scanline sprite render bank: collects up to NUM_SLOTS sprite entries,
// then scans LINE_W columns and emits the winning sprite pixel per column.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_valid/load_ready      slot entry handshake
//   load_x, load_attr          sprite X and attributes ([1:0] pal, [5] prio, [6] hflip)
//   load_lo, load_hi           pattern bitplanes for this row, bit 7 leftmost
//   load_is_zero               entry is OAM sprite 0
//   line_start                 begin scanning column 0
//   pix_en                     advance one column
//   pix_valid                  pixel outputs valid (one cycle after pix_en)
//   sp_color_idx               {palette, color}, 0 = transparent
//   sp_prio, sp_zero           winner priority, sprite-0 opaque flag
//   line_done                  pulse after the last column is output
// Config macro: SP_ZERO_HIT_EN enables sp_zero; otherwise it is tied to 0.
module sp_render_bank
  import sp_render_bank_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int LINE_W    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_x,
  input  logic [7:0] load_attr,
  input  logic [7:0] load_lo,
  input  logic [7:0] load_hi,
  input  logic       load_is_zero,
  input  logic       line_start,
  input  logic       pix_en,
  output logic       pix_valid,
  output logic [3:0] sp_color_idx,
  output logic       sp_prio,
  output logic       sp_zero,
  output logic       line_done
);

  localparam int FILL_W = $clog2(NUM_SLOTS + 1);
  localparam int COL_W  = $clog2(LINE_W) + 1;

  state_t                     state;
  logic [FILL_W-1:0]          fill;
  logic [COL_W-1:0]           col;
  logic                       load_hs;
  logic                       active_px;
  logic                       last_col;
  logic                       flush;
  logic [NUM_SLOTS-1:0][1:0]  color_vec;
  logic [NUM_SLOTS-1:0][1:0]  pal_vec;
  logic [NUM_SLOTS-1:0]       prio_vec;
  logic [NUM_SLOTS-1:0]       zero_vec;
  logic [3:0]                 win_idx;
  logic                       win_prio;
  logic                       unused_ok;

  assign load_ready = (state == ST_LOAD) && (fill < FILL_W'(NUM_SLOTS));
  assign load_hs    = load_valid && load_ready;
  assign active_px  = (state == ST_ACTIVE) && pix_en;
  assign last_col   = (col == COL_W'(LINE_W - 1));
  assign flush      = (state == ST_FLUSH);
  assign unused_ok  = ^zero_vec;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    sp_slot u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (flush),
      .load         (load_hs && (fill == FILL_W'(i))),
      .shift        (active_px),
      .load_x       (load_x),
      .load_attr    (load_attr),
      .load_lo      (load_lo),
      .load_hi      (load_hi),
      .load_is_zero (load_is_zero),
      .color        (color_vec[i]),
      .pal          (pal_vec[i]),
      .prio         (prio_vec[i]),
      .zero_px      (zero_vec[i])
    );
  end

  // Lowest opaque slot index wins: scan high to low so the last hit stands.
  always_comb begin
    win_idx  = 4'h0;
    win_prio = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (color_vec[i] != 2'b00) begin
        win_idx  = {pal_vec[i], color_vec[i]};
        win_prio = prio_vec[i];
      end
    end
  end

  // Scan control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      fill  <= '0;
      col   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_hs) fill <= fill + FILL_W'(1);
          if (line_start) begin
            state <= ST_ACTIVE;
            col   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (pix_en) begin
            col <= col + COL_W'(1);
            if (last_col) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state <= ST_LOAD;
          fill  <= '0;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid    <= 1'b0;
      sp_color_idx <= 4'h0;
      sp_prio      <= 1'b0;
      sp_zero      <= 1'b0;
      line_done    <= 1'b0;
    end else begin
      pix_valid <= active_px;
      line_done <= flush;
      if (active_px) begin
        sp_color_idx <= win_idx;
        sp_prio      <= win_prio;
`ifdef SP_ZERO_HIT_EN
        // Sprite-0 hit is never reported on the rightmost column
        sp_zero <= zero_vec[0] && !last_col;
`else
        sp_zero <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sp_render_bank.sv
`timescale 1ns/1ps
module tb_sp_render_bank;

  localparam int NUM_SLOTS = 8;
  localparam int LINE_W    = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_x, load_attr, load_lo, load_hi;
  logic       load_is_zero;
  logic       line_start;
  logic       pix_en;
  logic       pix_valid;
  logic [3:0] sp_color_idx;
  logic       sp_prio, sp_zero, line_done;

  sp_render_bank #(.NUM_SLOTS(NUM_SLOTS), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_x       (load_x),
    .load_attr    (load_attr),
    .load_lo      (load_lo),
    .load_hi      (load_hi),
    .load_is_zero (load_is_zero),
    .line_start   (line_start),
    .pix_en       (pix_en),
    .pix_valid    (pix_valid),
    .sp_color_idx (sp_color_idx),
    .sp_prio      (sp_prio),
    .sp_zero      (sp_zero),
    .line_done    (line_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    logic [7:0] attr;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       is_zero;
  } spr_t;

  typedef struct {
    int         col;
    logic [3:0] idx;
    logic       prio;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  spr_t offer[$];
  spr_t line_spr[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  function automatic spr_t mk(int x, logic [7:0] attr, logic [7:0] lo, logic [7:0] hi, logic z);
    spr_t s;
    s.x = x; s.attr = attr; s.lo = lo; s.hi = hi; s.is_zero = z;
    return s;
  endfunction

  // Reference: a sprite covers columns x..x+7; column offset k reads pattern
  // bit 7-k (bit k when flipped). First slot in load order with a nonzero
  // color wins.
  function automatic exp_t model_px(int c);
    exp_t e;
    e.col = c; e.idx = 4'h0; e.prio = 1'b0; e.zero = 1'b0;
    for (int s = line_spr.size() - 1; s >= 0; s--) begin
      int k;
      int b;
      logic [1:0] c2;
      k = c - line_spr[s].x;
      if (k >= 0 && k < 8) begin
        b  = line_spr[s].attr[6] ? k : 7 - k;
        c2 = {line_spr[s].hi[b], line_spr[s].lo[b]};
        if (c2 != 2'b00) begin
          e.idx  = {line_spr[s].attr[1:0], c2};
          e.prio = line_spr[s].attr[5];
`ifdef SP_ZERO_HIT_EN
          if (s == 0 && line_spr[0].is_zero && c != LINE_W - 1) e.zero = 1'b1;
`endif
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Offer every entry in 'offer'; the model accepts the first NUM_SLOTS.
  task automatic load_line(input bit coincide);
    int fill;
    fill = 0;
    line_spr.delete();
    for (int i = 0; i < offer.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        load_x     = 8'($urandom);
        pix_en     = 1'($urandom);
        line_start = 1'b0;
        @(posedge clk); #1;
      end
      load_valid   = 1'b1;
      load_x       = offer[i].x[7:0];
      load_attr    = offer[i].attr;
      load_lo      = offer[i].lo;
      load_hi      = offer[i].hi;
      load_is_zero = offer[i].is_zero;
      pix_en       = 1'($urandom);
      line_start   = coincide && (i == offer.size() - 1);
      check("load_ready", int'(load_ready), int'(fill < NUM_SLOTS));
      if (fill < NUM_SLOTS) begin
        line_spr.push_back(offer[i]);
        fill++;
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    pix_en     = 1'b0;
    if (!(coincide && offer.size() > 0)) begin
      line_start = 1'b1;
      @(posedge clk); #1;
    end
    line_start = 1'b0;
  endtask

  // Issue n accepted columns with random gaps and stray line_start pulses.
  task automatic run_cols(input int n);
    int issued;
    issued = 0;
    while (issued < n) begin
      pix_en     = ($urandom_range(0, 3) != 0);
      line_start = ($urandom_range(0, 7) == 0);
      if (pix_en) issued++;
      @(posedge clk); #1;
    end
    pix_en     = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("line_done_seen", done_cnt - start, 1);
  endtask

  task automatic do_line(input bit coincide);
    load_line(coincide);
    for (int c = 0; c < LINE_W; c++) exp_q.push_back(model_px(c));
    run_cols(LINE_W);
    wait_done();
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic rand_offer(input int n);
    offer.delete();
    for (int i = 0; i < n; i++)
      offer.push_back(mk($urandom_range(0, 255), 8'($urandom), 8'($urandom),
                         8'($urandom), 1'($urandom)));
  endtask

  // Monitor / scoreboard
  exp_t       mon_e;
  logic       prev_valid;
  int         prev_col;
  logic [3:0] last_idx;
  logic       last_prio, last_zero;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_col   = -1;
      last_idx   = 4'h0;
      last_prio  = 1'b0;
      last_zero  = 1'b0;
    end else begin
      if (pix_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          prev_col = -1;
          $display("FAIL unexpected_pix: pix_valid with no expected column, idx=%0h", sp_color_idx);
        end else begin
          mon_e = exp_q.pop_front();
          prev_col = mon_e.col;
          if (sp_color_idx !== mon_e.idx || sp_prio !== mon_e.prio || sp_zero !== mon_e.zero) begin
            fails++;
            $display("FAIL pixel col %0d: got idx=%0h prio=%0b zero=%0b expected idx=%0h prio=%0b zero=%0b",
                     mon_e.col, sp_color_idx, sp_prio, sp_zero, mon_e.idx, mon_e.prio, mon_e.zero);
          end
        end
      end else begin
        tests++;
        if (sp_color_idx !== last_idx || sp_prio !== last_prio || sp_zero !== last_zero) begin
          fails++;
          $display("FAIL hold: got idx=%0h prio=%0b zero=%0b expected idx=%0h prio=%0b zero=%0b",
                   sp_color_idx, sp_prio, sp_zero, last_idx, last_prio, last_zero);
        end
      end
      if (line_done) begin
        done_cnt++;
        tests++;
        if (!(prev_valid && prev_col == LINE_W - 1)) begin
          fails++;
          $display("FAIL line_done_timing: prev_valid=%0b prev_col=%0d expected 1 and %0d",
                   prev_valid, prev_col, LINE_W - 1);
        end
      end
      prev_valid = pix_valid;
      last_idx   = sp_color_idx;
      last_prio  = sp_prio;
      last_zero  = sp_zero;
    end
  end

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0; load_x = 8'h0; load_attr = 8'h0; load_lo = 8'h0; load_hi = 8'h0;
    load_is_zero = 1'b0; line_start = 1'b0; pix_en = 1'b0;
    #12;
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_color", int'(sp_color_idx), 0);
    check("rst_prio", int'(sp_prio), 0);
    check("rst_zero", int'(sp_zero), 0);
    check("rst_line_done", int'(line_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_load_ready", int'(load_ready), 1);

    // Single sprite, palette 2, leftmost pixel only
    offer.delete(); offer.push_back(mk(10, 8'h02, 8'h80, 8'h00, 1'b0));
    do_line(1'b0);
    // Same with horizontal flip
    offer.delete(); offer.push_back(mk(10, 8'h42, 8'h01, 8'h00, 1'b0));
    do_line(1'b0);
    // Overlap: lowest slot wins
    offer.delete();
    offer.push_back(mk(20, 8'h20, 8'h80, 8'h00, 1'b0));
    offer.push_back(mk(20, 8'h01, 8'h80, 8'h80, 1'b0));
    do_line(1'b0);
    // Transparent slot 0 lets slot 1 through
    offer.delete();
    offer.push_back(mk(20, 8'h20, 8'h00, 8'h00, 1'b0));
    offer.push_back(mk(20, 8'h01, 8'h80, 8'h80, 1'b0));
    do_line(1'b0);
    // NUM_SLOTS+1 entries; the extra one must never render
    offer.delete();
    for (int i = 0; i < NUM_SLOTS; i++) offer.push_back(mk(i * 20, 8'h00, 8'hFF, 8'h00, 1'b0));
    offer.push_back(mk(200, 8'h03, 8'hFF, 8'hFF, 1'b0));
    do_line(1'b0);
    // Sprite 0 at the last column, then mid-line under another sprite
    offer.delete(); offer.push_back(mk(255, 8'h00, 8'h80, 8'h00, 1'b1));
    do_line(1'b0);
    offer.delete();
    offer.push_back(mk(100, 8'h00, 8'hA5, 8'h00, 1'b1));
    offer.push_back(mk(98, 8'h02, 8'hFF, 8'hFF, 1'b0));
    do_line(1'b0);
    // Load coinciding with line_start
    offer.delete();
    offer.push_back(mk(30, 8'h01, 8'hFF, 8'h0F, 1'b0));
    offer.push_back(mk(33, 8'h02, 8'h3C, 8'hC3, 1'b0));
    do_line(1'b1);
    // Randomized lines
    for (int n = 0; n < 8; n++) begin
      rand_offer($urandom_range(0, NUM_SLOTS + 2));
      do_line(1'($urandom));
    end

    // Reset in the middle of a line
    offer.delete(); offer.push_back(mk(45, 8'h03, 8'hFF, 8'hFF, 1'b0));
    load_line(1'b0);
    for (int c = 0; c < LINE_W; c++) exp_q.push_back(model_px(c));
    run_cols(50);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pix_valid", int'(pix_valid), 0);
    check("midrst_color", int'(sp_color_idx), 0);
    check("midrst_prio", int'(sp_prio), 0);
    check("midrst_line_done", int'(line_done), 0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_load_ready", int'(load_ready), 1);
    offer.delete();
    offer.push_back(mk(60, 8'h21, 8'hC3, 8'h81, 1'b0));
    offer.push_back(mk(0, 8'h02, 8'h80, 8'h00, 1'b0));
    do_line(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sp_render_bank.md
SP_RENDER_BANK -- requirements
Module: sp_render_bank

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning the number of sprite slots per scanline (legal range 1..64).
REQ-002 SHALL have parameter LINE_W, default 256, meaning the number of pixel columns per active scanline.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1 bit: a slot entry is presented.
REQ-006 SHALL have port load_ready, output, 1 bit: the block accepts the entry this cycle.
REQ-007 SHALL have port load_x, input, 8 bits: sprite X position.
REQ-008 SHALL have port load_attr, input, 8 bits: [1:0] palette, [5] priority, [6] horizontal flip.
REQ-009 SHALL have ports load_lo and load_hi, inputs, 8 bits each: pattern bitplanes for the current row, bit 7 leftmost.
REQ-010 SHALL have port load_is_zero, input, 1 bit: the entry is OAM sprite 0.
REQ-011 SHALL have port line_start, input, 1 bit: pulse that begins scanning of column 0.
REQ-012 SHALL have port pix_en, input, 1 bit: advance one column.
REQ-013 SHALL have port pix_valid, output, 1 bit: the pixel outputs are valid this cycle.
REQ-014 SHALL have port sp_color_idx, output, 4 bits: {palette, color}; 0 means transparent.
REQ-015 SHALL have ports sp_prio and sp_zero, outputs, 1 bit each: priority of the winning sprite, and the sprite-0 opaque flag.
REQ-016 SHALL have port line_done, output, 1 bit: one-cycle pulse after the last column is output.

Function
REQ-017 SHALL implement the FSM states LOAD, ACTIVE and FLUSH; LOAD to ACTIVE on line_start; ACTIVE to FLUSH after LINE_W accepted pix_en; FLUSH to LOAD after one cycle, clearing all slots.
REQ-018 SHALL drive load_ready = (state==LOAD) and (fill count < NUM_SLOTS), and fill slots in arrival order starting at index 0.
REQ-019 SHALL, on a load handshake, store the pattern bit-reversed when attr[6]=1, so that the shifter always emits its MSB first.
REQ-020 SHALL ignore load_valid without load_ready: no state change, and no error.
REQ-021 SHALL, if load and line_start coincide in LOAD, accept the entry and have it participate in the line.
REQ-022 SHALL, per accepted pix_en in ACTIVE: decrement a nonzero slot X counter; for a slot whose X counter is 0, shift its bitplanes left by 1 for at most 8 shifts, after which the slot outputs transparent.
REQ-023 SHALL take the pixel of each slot from its shifter MSBs, evaluated before the shift in the pix_en cycle.
REQ-024 SHALL select, among loaded slots with a nonzero color, the lowest slot index as the winner.
REQ-025 SHALL register the outputs with 1-cycle latency: pix_valid is high the cycle after each accepted pix_en in ACTIVE, and the outputs describe column n = the count of prior pix_en in this line.
REQ-026 SHALL, with no opaque slot, output sp_color_idx=0 and sp_prio=0.
REQ-027 SHALL ignore line_start in ACTIVE and FLUSH, and ignore pix_en outside ACTIVE.
REQ-028 SHALL keep the outputs holding their last values while pix_valid=0.
REQ-029 SHALL size the column counter to $clog2(LINE_W)+1 bits, and make X counters saturate at 0.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set: state=LOAD; fill count=0; all slots unloaded; load_ready=1 after release; pix_valid=0, sp_color_idx=0, sp_prio=0, sp_zero=0, line_done=0.
REQ-031 SHALL, when reset occurs mid-line, abandon the line; the first line_start after release starts a fresh line.

Configuration
REQ-032 SHALL support macro SP_ZERO_HIT_EN: when defined, sp_zero=1 when slot 0 holds load_is_zero=1 and the slot 0 pixel is opaque, regardless of which slot wins, and never for column LINE_W-1.
REQ-033 SHALL, when SP_ZERO_HIT_EN is undefined, tie sp_zero to 0 and not store the is_zero flag.

Structure
REQ-034 SHALL place in the shared PPU package: the slot record type (x, attr, lo, hi, is_zero, loaded), the state enum, and the attribute bit-index constants.
REQ-035 SHALL use one sub-module, sp_slot, that holds one slot's counter and shifter, instantiated NUM_SLOTS times via generate; the priority select stays in the top.

Verification
REQ-036 SHALL verify: one sprite with x=10, lo=8'h80, hi=0, pal=2 -> column 10 gives sp_color_idx=4'h9, and columns 9 and 11 give 0.
REQ-037 SHALL verify: the same sprite with attr[6]=1 and lo=8'h01 -> opaque at column 10 only.
REQ-038 SHALL verify: slot0 (x=20, color 1) and slot1 (x=20, color 3) -> column 20 gives color 1; with slot0 color 0, column 20 gives color 3 from slot1.
REQ-039 SHALL verify: offering NUM_SLOTS+1 entries -> load_ready falls after NUM_SLOTS accepts; the extra entry never renders.
REQ-040 SHALL verify: with SP_ZERO_HIT_EN, slot0 is_zero with x=255 opaque -> sp_zero=0 at column 255; with x=100 -> sp_zero=1 at column 100.
REQ-041 SHALL verify: rst_n asserted at column 50 -> the outputs zero immediately; the next line renders correctly after LINE_W pix_en and one line_done.
